// File: rtl/cg_cfg_spi.sv
// rtl/cg_cfg_spi.sv - SPI-slave register front end driving cg_core configuration inputs
// Pins are oversampled in the clk domain; a 32-bit frame commits only on a clean CS_N rise.
module cg_cfg_spi #(
    parameter int SYNC_STAGES = 2,
    parameter int DW          = 24
) (
    input  logic          clk,
    input  logic          I_RST_N,
    input  logic          I_SCK,
    input  logic          I_CS_N,
    input  logic          I_MOSI,
    output logic          O_MISO,
    input  logic          I_RTE,
    input  logic [DW-1:0] I_ACC,
    output logic [DW-1:0] O_LMT,
    output logic [DW-1:0] O_DLY,
    output logic          O_OE,
    output logic          O_EN,
    output logic          O_DDS,
    output logic          O_LDS,
    output logic          O_LEN,
    output logic          O_WSTB
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_d, cs_d;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, cs_rise, cs_fall;
    logic [5:0]             bit_cnt;
    logic [31:0]            frame;
    logic [DW-1:0]          rd_sh, rd_val;
    logic                   rd_act, ferr;
    logic [4:0]             ctrl;
    logic [6:0]             snap_addr;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d;

    assign {O_LEN, O_LDS, O_DDS, O_EN, O_OE} = ctrl;

    // CS_N syncs reset low so a CS_N already low at release never looks like a fresh fall
    always_ff @(posedge clk or negedge I_RST_N) begin
        if (!I_RST_N) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], I_SCK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], I_CS_N};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], I_MOSI};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
        end
    end

    always_ff @(posedge clk or negedge I_RST_N) begin
        if (!I_RST_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = SHIFT;
            SHIFT:   if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address completes with the MOSI bit sampled on the 8th rise itself
    assign snap_addr = {frame[5:0], mosi_s};

    always_comb begin
        rd_val = '0;
        case (snap_addr)
            7'h00:   rd_val = O_LMT;
            7'h01:   rd_val = O_DLY;
            7'h02:   rd_val = {{(DW-5){1'b0}}, ctrl};
            7'h03:   rd_val = {{(DW-2){1'b0}}, ferr, I_RTE};
            7'h04:   rd_val = I_ACC;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge I_RST_N) begin
        if (!I_RST_N) begin
            bit_cnt <= '0;
            frame   <= '0;
            rd_sh   <= '0;
            rd_act  <= 1'b0;
            ferr    <= 1'b0;
            ctrl    <= '0;
            O_LMT   <= '0;
            O_DLY   <= '0;
            O_MISO  <= 1'b0;
            O_WSTB  <= 1'b0;
        end else begin
            O_WSTB <= 1'b0;
            if (state_q == IDLE) begin
                bit_cnt <= '0;
                rd_act  <= 1'b0;
                O_MISO  <= 1'b0;
            end else if (cs_rise) begin
                O_MISO <= 1'b0;
                if (bit_cnt == 6'd32) begin
                    if (frame[31]) begin
                        case (frame[30:24])
                            7'h00: begin O_LMT <= frame[DW-1:0]; O_WSTB <= 1'b1; end
                            7'h01: begin O_DLY <= frame[DW-1:0]; O_WSTB <= 1'b1; end
                            7'h02: begin ctrl  <= frame[4:0];    O_WSTB <= 1'b1; end
                            default: ;
                        endcase
                    end else if (frame[30:24] == 7'h03) begin
                        ferr <= 1'b0;
                    end
                end else begin
                    ferr <= 1'b1;
                end
            end else if (sck_rise) begin
                if (bit_cnt != 6'd33) bit_cnt <= bit_cnt + 6'd1;
                if (bit_cnt < 6'd32)  frame   <= {frame[30:0], mosi_s};
                if (bit_cnt == 6'd7) begin
                    rd_act <= ~frame[6];
                    rd_sh  <= rd_val;
                end
            end else if (sck_fall && rd_act && bit_cnt >= 6'd8) begin
                O_MISO <= rd_sh[DW-1];
                rd_sh  <= {rd_sh[DW-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_cg_cfg_spi.sv
// tb/tb_cg_cfg_spi.sv - scoreboard bench for cg_cfg_spi
module tb_cg_cfg_spi;

    logic        clk = 1'b0;
    logic        I_RST_N, I_SCK, I_CS_N, I_MOSI, I_RTE;
    logic        O_MISO, O_OE, O_EN, O_DDS, O_LDS, O_LEN, O_WSTB;
    logic [23:0] I_ACC, O_LMT, O_DLY;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          wq[$];
    logic [31:0] rq[$];

    function automatic logic [23:0] acc_f(input int c);
        return 24'(c * 4099 + 17);
    endfunction

    assign I_ACC = acc_f(cyc);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cg_cfg_spi #(.SYNC_STAGES(2), .DW(24)) dut (
        .clk(clk), .I_RST_N(I_RST_N), .I_SCK(I_SCK), .I_CS_N(I_CS_N),
        .I_MOSI(I_MOSI), .O_MISO(O_MISO), .I_RTE(I_RTE), .I_ACC(I_ACC),
        .O_LMT(O_LMT), .O_DLY(O_DLY), .O_OE(O_OE), .O_EN(O_EN),
        .O_DDS(O_DDS), .O_LDS(O_LDS), .O_LEN(O_LEN), .O_WSTB(O_WSTB)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (I_RST_N === 1'b1 && O_WSTB === 1'b1) begin
            if (wq.size() == 0) check("wstb_extra", 32'd1, 32'd0);
            else                check("wstb_cycle", cyc, wq.pop_front());
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Mode-0 master; MISO is sampled at the end of each SCK-low half
    task automatic spi_xfer(input logic [63:0] w, input int nbits, input int rst_at,
                            input bit exp_wstb, output logic [31:0] rd, output int r8);
        rd = '0;
        r8 = -1;
        I_SCK = 1'b0;
        I_CS_N = 1'b0;
        wait_clk(5);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                I_RST_N = 1'b0;
                wait_clk(3);
                I_RST_N = 1'b1;
                wait_clk(2);
            end
            I_MOSI = w[63-i];
            wait_clk(5);
            rd = {rd[30:0], O_MISO};
            if (i == 7) r8 = cyc;
            I_SCK = 1'b1;
            wait_clk(5);
            I_SCK = 1'b0;
        end
        wait_clk(5);
        if (exp_wstb) wq.push_back(cyc + 3);
        I_CS_N = 1'b1;
        wait_clk(10);
    endtask

    task automatic wr(input logic [6:0] addr, input logic [23:0] data, input bit commits);
        logic [31:0] rd;
        int r8;
        spi_xfer({1'b1, addr, data, 32'h0}, 32, -1, commits, rd, r8);
    endtask

    task automatic rd_chk(input string tag, input logic [6:0] addr, input logic [23:0] exp);
        logic [31:0] rd;
        int r8;
        rq.push_back({8'h0, exp});
        spi_xfer({1'b0, addr, 24'h0, 32'h0}, 32, -1, 1'b0, rd, r8);
        check(tag, rd, rq.pop_front());
    endtask

    function automatic logic [4:0] ctrl_out();
        return {O_LEN, O_LDS, O_DDS, O_EN, O_OE};
    endfunction

    initial begin
        logic [31:0] rd;
        int r8;
        I_RST_N = 1'b0;
        I_SCK = 1'b0;
        I_CS_N = 1'b1;
        I_MOSI = 1'b0;
        I_RTE = 1'b1;
        wait_clk(3);
        check("rst_lmt", O_LMT, 0);
        check("rst_dly", O_DLY, 0);
        check("rst_ctrl", ctrl_out(), 0);
        check("rst_miso", O_MISO, 0);
        I_RST_N = 1'b1;
        wait_clk(5);

        wr(7'h00, 24'd20, 1'b1);
        check("lmt_w", O_LMT, 20);
        wr(7'h01, 24'd10, 1'b1);
        check("dly_w", O_DLY, 10);
        wr(7'h02, 24'hFFFF1F, 1'b1);
        check("ctrl_w", ctrl_out(), 5'h1F);

        rd_chk("rd_lmt", 7'h00, 24'd20);
        rd_chk("rd_dly", 7'h01, 24'h00000A);
        rd_chk("rd_ctrl", 7'h02, 24'h00001F);

        spi_xfer({8'h04, 24'h0, 32'h0}, 32, -1, 1'b0, rd, r8);
        check("rd_acc", rd, {8'h0, acc_f(r8 + 2)});

        spi_xfer({8'h80, 24'd5, 32'h0}, 31, -1, 1'b0, rd, r8);
        check("short_lmt", O_LMT, 20);
        rd_chk("stat_ferr_short", 7'h03, 24'h3);
        rd_chk("stat_ferr_clr", 7'h03, 24'h1);
        spi_xfer({8'h80, 24'd5, 32'h0}, 33, -1, 1'b0, rd, r8);
        check("long_lmt", O_LMT, 20);
        I_RTE = 1'b0;
        rd_chk("stat_ferr_long", 7'h03, 24'h2);
        rd_chk("stat_ferr_clr2", 7'h03, 24'h0);
        I_RTE = 1'b1;

        wr(7'h04, 24'd99, 1'b0);
        wr(7'h7F, 24'd99, 1'b0);
        check("ign_lmt", O_LMT, 20);
        check("ign_dly", O_DLY, 10);
        check("ign_ctrl", ctrl_out(), 5'h1F);
        rd_chk("ign_stat", 7'h03, 24'h1);

        spi_xfer({8'h82, 24'h00001F, 32'h0}, 32, 16, 1'b0, rd, r8);
        check("mid_rst_lmt", O_LMT, 0);
        check("mid_rst_dly", O_DLY, 0);
        check("mid_rst_ctrl", ctrl_out(), 0);
        rd_chk("mid_rst_stat", 7'h03, 24'h1);
        wr(7'h00, 24'd7, 1'b1);
        check("post_rst_lmt", O_LMT, 7);

        check("wstb_pending", wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
